// File: rtl/uart_ir_loader.sv
// ---------------------------------------------------------------------------
// uart_ir_loader
//
// Loads a program image received over a UART RX pin into the instruction
// RAM. It writes through the same data/address/wren interface that the
// processor uses. While a frame is in progress, busy is high so that the top
// level can hold the processor in reset.
//
// Frame (all bytes): 0xA5, N_hi, N_lo, N words (hi byte then lo byte), CSUM
//   CSUM = XOR of every byte between the 0xA5 header and the CSUM byte.
//
// Ports:
//   clock        in   system clock, all logic on posedge
//   reset        in   synchronous, active-high
//   rx           in   UART receive line (asynchronous, idle high)
//   ir_m_data    out  16-bit write data to ir RAM
//   ir_m_addr    out  ADDR_W-bit write address to ir RAM
//   ir_m_wren    out  one-cycle write strobe
//   busy         out  frame in progress
//   done         out  one-cycle pulse when a frame is accepted
//   err          out  sticky error flag, cleared by the next 0xA5 header
//   words_loaded out  word count of the last accepted frame
//   tx           out  UART transmit line (echo of received bytes, or idle)
//
// Optional feature macro: UART_IR_LOADER_ECHO_EN
//   When this macro is defined, an 8N1 transmitter runs at the same bit
//   rate and echoes every received byte on tx. It uses a one-byte holding
//   register. When the macro is undefined, tx is tied high.
// ---------------------------------------------------------------------------
module uart_ir_loader #(
    parameter int CLK_HZ  = 60000000,
    parameter int BAUD    = 115200,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 6000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    output logic [15:0]       ir_m_data,
    output logic [ADDR_W-1:0] ir_m_addr,
    output logic              ir_m_wren,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded,
    output logic              tx
);

    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [16:0]      MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0]  WCNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    // -----------------------------------------------------------------------
    // RX synchronizer and sampler
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rxState_t;

    rxState_t         r_rxState, w_rxStateNext;
    logic             r_rxMeta, r_rxSync, r_rxPrev;
    logic [CNT_W-1:0] r_rxCnt, w_rxCntNext;
    logic [7:0]       r_rxShift, w_rxShiftNext;
    logic [2:0]       r_rxBit, w_rxBitNext;
    logic             r_byteValid, w_byteValidNext;
    logic             r_frameErr, w_frameErrNext;
    logic [7:0]       w_rxByte;

    // The shift register holds the completed byte from the last data bit
    // until the next start bit. It is therefore stable while byte_valid is high.
    assign w_rxByte = r_rxShift;

    // The synchronizer flops reset to the idle-high level. This stops a
    // reset release from looking like a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rxMeta    <= 1'b1;
            r_rxSync    <= 1'b1;
            r_rxPrev    <= 1'b1;
            r_rxState   <= RX_IDLE;
            r_rxCnt     <= '0;
            r_rxShift   <= '0;
            r_rxBit     <= '0;
            r_byteValid <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_rxMeta    <= rx;
            r_rxSync    <= r_rxMeta;
            r_rxPrev    <= r_rxSync;
            r_rxState   <= w_rxStateNext;
            r_rxCnt     <= w_rxCntNext;
            r_rxShift   <= w_rxShiftNext;
            r_rxBit     <= w_rxBitNext;
            r_byteValid <= w_byteValidNext;
            r_frameErr  <= w_frameErrNext;
        end
    end

    // The sampler checks the start bit half a bit after the falling edge.
    // It then samples each later bit one full bit period apart, so every
    // sample lands near the middle of its bit.
    always_comb begin
        w_rxStateNext   = r_rxState;
        w_rxCntNext     = r_rxCnt + CNT_ONE;
        w_rxShiftNext   = r_rxShift;
        w_rxBitNext     = r_rxBit;
        w_byteValidNext = 1'b0;
        w_frameErrNext  = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                w_rxCntNext = '0;
                if (r_rxPrev && !r_rxSync) begin
                    w_rxStateNext = RX_START;
                end
            end
            RX_START: begin
                if (r_rxCnt == HALF_LAST) begin
                    w_rxCntNext = '0;
                    w_rxBitNext = '0;
                    if (r_rxSync) begin
                        w_rxStateNext = RX_IDLE;
                    end else begin
                        w_rxStateNext = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (r_rxCnt == DIV_LAST) begin
                    w_rxCntNext   = '0;
                    w_rxShiftNext = {r_rxSync, r_rxShift[7:1]};
                    w_rxBitNext   = r_rxBit + 3'd1;
                    if (r_rxBit == 3'd7) begin
                        w_rxStateNext = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_rxCnt == DIV_LAST) begin
                    w_rxCntNext     = '0;
                    w_byteValidNext = r_rxSync;
                    w_frameErrNext  = !r_rxSync;
                    w_rxStateNext   = RX_WAIT;
                end
            end
            RX_WAIT: begin
                // After a framing error the line may stay low for a long
                // time. Wait for it to go high before arming again.
                w_rxCntNext = '0;
                if (r_rxSync) begin
                    w_rxStateNext = RX_IDLE;
                end
            end
            default: begin
                w_rxStateNext = RX_IDLE;
                w_rxCntNext   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA_H,
        ST_DATA_L,
        ST_CSUM,
        ST_ERR
    } state_t;

    state_t            r_state, w_stateNext;
    logic [7:0]        r_nHi;
    logic [ADDR_W:0]   r_nWords;
    logic [ADDR_W:0]   r_wordCnt;
    logic [7:0]        r_hiByte;
    logic [7:0]        r_xor;
    logic [TO_W-1:0]   r_toCnt;
    logic [15:0]       r_irData;
    logic [ADDR_W-1:0] r_irAddr;
    logic              r_irWren;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_wordsLoaded;

    logic              w_timeout;
    logic [16:0]       w_nFull;
    logic [ADDR_W:0]   w_cntInc;
    logic              w_startFrame;
    logic              w_xorUpdate;
    logic              w_latchNHi;
    logic              w_latchN;
    logic              w_latchHi;
    logic              w_wrStrobe;
    logic              w_doneStrobe;

    assign w_timeout = (r_toCnt == TO_LAST);
    assign w_nFull   = {1'b0, r_nHi, w_rxByte};
    assign w_cntInc  = r_wordCnt + WCNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A framing error or a timeout in any active state ends the frame.
    // A framing error and a valid byte never occur in the same cycle, so
    // the framing error can safely be checked first.
    always_comb begin
        w_stateNext  = r_state;
        w_startFrame = 1'b0;
        w_xorUpdate  = 1'b0;
        w_latchNHi   = 1'b0;
        w_latchN     = 1'b0;
        w_latchHi    = 1'b0;
        w_wrStrobe   = 1'b0;
        w_doneStrobe = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_byteValid && (w_rxByte == SYNC_BYTE)) begin
                    w_startFrame = 1'b1;
                    w_stateNext  = ST_LEN_H;
                end
            end
            ST_ERR: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                if (r_frameErr) begin
                    w_stateNext = ST_ERR;
                end else if (r_byteValid) begin
                    case (r_state)
                        ST_LEN_H: begin
                            w_xorUpdate = 1'b1;
                            w_latchNHi  = 1'b1;
                            w_stateNext = ST_LEN_L;
                        end
                        ST_LEN_L: begin
                            w_xorUpdate = 1'b1;
                            w_latchN    = 1'b1;
                            if ((w_nFull == 17'd0) || (w_nFull > MAX_WORDS)) begin
                                w_stateNext = ST_ERR;
                            end else begin
                                w_stateNext = ST_DATA_H;
                            end
                        end
                        ST_DATA_H: begin
                            w_xorUpdate = 1'b1;
                            w_latchHi   = 1'b1;
                            w_stateNext = ST_DATA_L;
                        end
                        ST_DATA_L: begin
                            w_xorUpdate = 1'b1;
                            w_wrStrobe  = 1'b1;
                            if (w_cntInc == r_nWords) begin
                                w_stateNext = ST_CSUM;
                            end else begin
                                w_stateNext = ST_DATA_H;
                            end
                        end
                        ST_CSUM: begin
                            if (w_rxByte == r_xor) begin
                                w_doneStrobe = 1'b1;
                                w_stateNext  = ST_IDLE;
                            end else begin
                                w_stateNext = ST_ERR;
                            end
                        end
                        default: begin
                            w_stateNext = ST_IDLE;
                        end
                    endcase
                end else if (w_timeout) begin
                    w_stateNext = ST_ERR;
                end
            end
        endcase
    end

    // Datapath registers. Data and address are registered together with the
    // write strobe and keep their values between writes. The RAM is clocked
    // on the inverted clock, so it sees stable values at its write edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_nHi         <= '0;
            r_nWords      <= '0;
            r_wordCnt     <= '0;
            r_hiByte      <= '0;
            r_xor         <= '0;
            r_toCnt       <= '0;
            r_irData      <= '0;
            r_irAddr      <= '0;
            r_irWren      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_wordsLoaded <= '0;
        end else begin
            r_irWren <= w_wrStrobe;
            r_done   <= w_doneStrobe;

            if ((r_state == ST_IDLE) || r_byteValid) begin
                r_toCnt <= '0;
            end else if (!w_timeout) begin
                r_toCnt <= r_toCnt + TO_ONE;
            end

            if (w_startFrame) begin
                r_busy    <= 1'b1;
                r_err     <= 1'b0;
                r_xor     <= '0;
                r_wordCnt <= '0;
            end
            if (w_xorUpdate) begin
                r_xor <= r_xor ^ w_rxByte;
            end
            if (w_latchNHi) begin
                r_nHi <= w_rxByte;
            end
            if (w_latchN) begin
                r_nWords <= w_nFull[ADDR_W:0];
            end
            if (w_latchHi) begin
                r_hiByte <= w_rxByte;
            end
            if (w_wrStrobe) begin
                r_irData  <= {r_hiByte, w_rxByte};
                r_irAddr  <= r_wordCnt[ADDR_W-1:0];
                r_wordCnt <= w_cntInc;
            end
            if (w_doneStrobe) begin
                r_wordsLoaded <= r_nWords;
                r_busy        <= 1'b0;
            end
            if (r_state == ST_ERR) begin
                r_err  <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign ir_m_data    = r_irData;
    assign ir_m_addr    = r_irAddr;
    assign ir_m_wren    = r_irWren;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_wordsLoaded;

`ifdef UART_IR_LOADER_ECHO_EN
    // -----------------------------------------------------------------------
    // Echo transmitter
    // -----------------------------------------------------------------------
    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } txState_t;

    txState_t         r_txState, w_txStateNext;
    logic [7:0]       r_txHold, w_txHoldNext;
    logic             r_txHoldValid, w_txHoldValidNext;
    logic [9:0]       r_txShift, w_txShiftNext;
    logic [3:0]       r_txBitsLeft, w_txBitsLeftNext;
    logic [CNT_W-1:0] r_txCnt, w_txCntNext;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_txState     <= TX_IDLE;
            r_txHold      <= '0;
            r_txHoldValid <= 1'b0;
            r_txShift     <= '1;
            r_txBitsLeft  <= '0;
            r_txCnt       <= '0;
        end else begin
            r_txState     <= w_txStateNext;
            r_txHold      <= w_txHoldNext;
            r_txHoldValid <= w_txHoldValidNext;
            r_txShift     <= w_txShiftNext;
            r_txBitsLeft  <= w_txBitsLeftNext;
            r_txCnt       <= w_txCntNext;
        end
    end

    // The shifter holds {stop, data, start} and is sent LSB first. A byte
    // that arrives while the line is busy waits in the holding register.
    // The capture of a new byte is applied last, so it wins over the
    // clearing of the holding register in the same cycle.
    always_comb begin
        w_txStateNext     = r_txState;
        w_txHoldNext      = r_txHold;
        w_txHoldValidNext = r_txHoldValid;
        w_txShiftNext     = r_txShift;
        w_txBitsLeftNext  = r_txBitsLeft;
        w_txCntNext       = r_txCnt;
        case (r_txState)
            TX_IDLE: begin
                if (r_txHoldValid) begin
                    w_txShiftNext     = {1'b1, r_txHold, 1'b0};
                    w_txBitsLeftNext  = 4'd9;
                    w_txCntNext       = '0;
                    w_txHoldValidNext = 1'b0;
                    w_txStateNext     = TX_SEND;
                end
            end
            TX_SEND: begin
                if (r_txCnt == DIV_LAST) begin
                    w_txCntNext = '0;
                    if (r_txBitsLeft == 4'd0) begin
                        w_txStateNext = TX_IDLE;
                    end else begin
                        w_txShiftNext    = {1'b1, r_txShift[9:1]};
                        w_txBitsLeftNext = r_txBitsLeft - 4'd1;
                    end
                end else begin
                    w_txCntNext = r_txCnt + CNT_ONE;
                end
            end
            default: begin
                w_txStateNext = TX_IDLE;
            end
        endcase
        if (r_byteValid) begin
            w_txHoldNext      = w_rxByte;
            w_txHoldValidNext = 1'b1;
        end
    end

    assign tx = (r_txState == TX_SEND) ? r_txShift[0] : 1'b1;
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_ir_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_ir_loader
//
// Testbench for uart_ir_loader. It uses scaled parameters so that frames,
// timeouts and full-size images fit in a short run:
//   DIV = 16 clocks per bit, ADDR_W = 4 (16 words), TIMEOUT = 1000 clocks.
// First a table of fixed frames is checked against hand-computed results.
// Hand-written sequences then cover noise and false starts, timeout, and
// reset in the middle of a frame. Last, random frames are checked against
// a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_ir_loader;

    localparam int CLK_HZ  = 1600000;
    localparam int BAUD    = 100000;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 1000;
    localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF    = DIV / 2;
    localparam int WORDS   = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              rx    = 1'b1;
    logic [15:0]       ir_m_data;
    logic [ADDR_W-1:0] ir_m_addr;
    logic              ir_m_wren;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;
    logic              tx;

    uart_ir_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .ir_m_data   (ir_m_data),
        .ir_m_addr   (ir_m_addr),
        .ir_m_wren   (ir_m_wren),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded),
        .tx          (tx)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Write and done activity recorded by the monitor on the falling edge.
    logic [ADDR_W-1:0] wrA[$];
    logic [15:0]       wrD[$];
    int                doneSeen = 0;

    always @(negedge clock) begin
        if (ir_m_wren) begin
            wrA.push_back(ir_m_addr);
            wrD.push_back(ir_m_data);
        end
        if (done) begin
            doneSeen++;
        end
    end

`ifdef UART_IR_LOADER_ECHO_EN
    logic [8:0] echoQ[$];

    always begin : echoMon
        logic [8:0] v;
        @(negedge tx);
        repeat (HALF) @(negedge clock);
        for (int k = 0; k < 9; k++) begin
            repeat (DIV) @(negedge clock);
            v[k] = tx;
        end
        echoQ.push_back(v);
    end
`endif

    // Reference model state, kept across frames.
    logic [7:0]        txBytes[$];
    logic [ADDR_W-1:0] expA[$];
    logic [15:0]       expD[$];
    int                expDone;
    logic              expErr = 1'b0;
    int                expWl  = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clock);
        rx = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clock);
        end
        rx = 1'b1;
        repeat (DIV) @(negedge clock);
    endtask

    task automatic applyStimulus(input int maxGap);
        foreach (txBytes[i]) begin
            repeat ($urandom_range(0, maxGap)) @(negedge clock);
            sendByte(txBytes[i]);
        end
    endtask

    // Frame-level model: scan the byte stream for headers, then apply the
    // length, payload and checksum rules directly to the byte list.
    task automatic modelFrame();
        int i;
        int n;
        logic [7:0] sum;
        expA.delete();
        expD.delete();
        expDone = 0;
        i = 0;
        while (i < txBytes.size()) begin
            if (txBytes[i] != 8'hA5) begin
                i++;
                continue;
            end
            expErr = 1'b0;
            n = {txBytes[i+1], txBytes[i+2]};
            if (n == 0 || n > WORDS) begin
                expErr = 1'b1;
                i += 3;
                continue;
            end
            sum = 8'h00;
            for (int k = 1; k <= 2 + 2 * n; k++) begin
                sum ^= txBytes[i+k];
            end
            for (int w = 0; w < n; w++) begin
                expA.push_back(ADDR_W'(w));
                expD.push_back({txBytes[i+3+2*w], txBytes[i+4+2*w]});
            end
            if (txBytes[i+3+2*n] == sum) begin
                expDone++;
                expWl = n;
            end else begin
                expErr = 1'b1;
            end
            i += 4 + 2 * n;
        end
    endtask

    task automatic runModelFrame(input string tag, input int maxGap);
        int baseW;
        int baseD;
        baseW = wrA.size();
        baseD = doneSeen;
        applyStimulus(maxGap);
        repeat (3 * DIV) @(negedge clock);
        modelFrame();
        checkOutput({tag, ".nwr"}, wrA.size() - baseW, expA.size());
        for (int k = 0; k < expA.size() && baseW + k < wrA.size(); k++) begin
            checkOutput($sformatf("%s.addr%0d", tag, k), wrA[baseW+k], expA[k]);
            checkOutput($sformatf("%s.data%0d", tag, k), wrD[baseW+k], expD[k]);
        end
        checkOutput({tag, ".done"}, doneSeen - baseD, expDone);
        checkOutput({tag, ".err"}, err, expErr);
        checkOutput({tag, ".wl"}, words_loaded, expWl);
        checkOutput({tag, ".busy"}, busy, 0);
`ifndef UART_IR_LOADER_ECHO_EN
        checkOutput({tag, ".tx"}, tx, 1);
`endif
    endtask

    task automatic buildFrame(input int n, input bit corrupt, input int noise);
        logic [7:0] b;
        logic [7:0] sum;
        txBytes.delete();
        for (int k = 0; k < noise; k++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            txBytes.push_back(b);
        end
        txBytes.push_back(8'hA5);
        txBytes.push_back(n[15:8]);
        txBytes.push_back(n[7:0]);
        sum = n[15:8] ^ n[7:0];
        for (int k = 0; k < 2 * n; k++) begin
            b = 8'($urandom);
            txBytes.push_back(b);
            sum ^= b;
        end
        if (corrupt) sum ^= 8'(1 << $urandom_range(0, 7));
        txBytes.push_back(sum);
    endtask

    typedef struct {
        string       name;
        int          len;
        logic [63:0] bytes;
        int          expDone;
        logic        expErr;
        int          expWl;
        int          nWr;
        logic [3:0]  wa0;
        logic [15:0] wd0;
        logic [3:0]  wa1;
        logic [15:0] wd1;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : main
        int baseW;
        int baseD;
        logic [ADDR_W-1:0] gotA;
        logic [15:0]       gotD;

        vecs[0] = '{"load",    8, 64'hA5_00_02_12_34_AB_CD_42, 1, 1'b0, 2, 2, 4'h0, 16'h1234, 4'h1, 16'hABCD};
        vecs[1] = '{"badcsum", 8, 64'hA5_00_02_12_34_AB_CD_43, 0, 1'b1, 2, 2, 4'h0, 16'h1234, 4'h1, 16'hABCD};
        vecs[2] = '{"nzero",   3, 64'hA5_00_00_00_00_00_00_00, 0, 1'b1, 2, 0, 4'h0, 16'h0000, 4'h0, 16'h0000};
        vecs[3] = '{"novf",    3, 64'hA5_00_11_00_00_00_00_00, 0, 1'b1, 2, 0, 4'h0, 16'h0000, 4'h0, 16'h0000};
        vecs[4] = '{"nbig",    3, 64'hA5_10_01_00_00_00_00_00, 0, 1'b1, 2, 0, 4'h0, 16'h0000, 4'h0, 16'h0000};
        vecs[5] = '{"hdrdata", 6, 64'hA5_00_01_A5_A5_01_00_00, 1, 1'b0, 1, 1, 4'h0, 16'hA5A5, 4'h0, 16'h0000};

        // Reset state
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst.data", ir_m_data, 0);
        checkOutput("rst.addr", ir_m_addr, 0);
        checkOutput("rst.wren", ir_m_wren, 0);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.err", err, 0);
        checkOutput("rst.wl", words_loaded, 0);
        checkOutput("rst.tx", tx, 1);

        // Table-driven fixed frames
        foreach (vecs[v]) begin
            txBytes.delete();
            for (int k = 0; k < vecs[v].len; k++) begin
                txBytes.push_back(vecs[v].bytes[63-8*k -: 8]);
            end
            baseW = wrA.size();
            baseD = doneSeen;
            applyStimulus(2);
            repeat (3 * DIV) @(negedge clock);
            checkOutput({vecs[v].name, ".nwr"}, wrA.size() - baseW, vecs[v].nWr);
            if (vecs[v].nWr > 0 && wrA.size() > baseW) begin
                checkOutput({vecs[v].name, ".addr0"}, wrA[baseW], vecs[v].wa0);
                checkOutput({vecs[v].name, ".data0"}, wrD[baseW], vecs[v].wd0);
            end
            if (vecs[v].nWr > 1 && wrA.size() > baseW + 1) begin
                checkOutput({vecs[v].name, ".addr1"}, wrA[baseW+1], vecs[v].wa1);
                checkOutput({vecs[v].name, ".data1"}, wrD[baseW+1], vecs[v].wd1);
            end
            checkOutput({vecs[v].name, ".done"}, doneSeen - baseD, vecs[v].expDone);
            checkOutput({vecs[v].name, ".err"}, err, vecs[v].expErr);
            checkOutput({vecs[v].name, ".wl"}, words_loaded, vecs[v].expWl);
            checkOutput({vecs[v].name, ".busy"}, busy, 0);
            expErr = vecs[v].expErr;
            expWl  = vecs[v].expWl;
        end

        // Noise bytes, a short false start, and a long low that ends in a
        // framing error while idle. None of these may start a frame.
        baseW = wrA.size();
        txBytes.delete();
        txBytes.push_back(8'h00);
        txBytes.push_back(8'hFF);
        applyStimulus(0);
        @(negedge clock);
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clock);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clock);
        rx = 1'b0;
        repeat (12 * DIV) @(negedge clock);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clock);
        checkOutput("noise.nwr", wrA.size() - baseW, 0);
        checkOutput("noise.busy", busy, 0);
        checkOutput("noise.err", err, 0);
        txBytes.delete();
        txBytes.push_back(8'hA5);
        txBytes.push_back(8'h00);
        txBytes.push_back(8'h01);
        txBytes.push_back(8'h5A);
        txBytes.push_back(8'hC3);
        txBytes.push_back(8'h98);
        runModelFrame("noise", 3);

        // Timeout: the frame stops after the hi byte of the first word.
        txBytes.delete();
        txBytes.push_back(8'hA5);
        txBytes.push_back(8'h00);
        txBytes.push_back(8'h02);
        txBytes.push_back(8'h12);
        applyStimulus(0);
        repeat (TIMEOUT / 2) @(negedge clock);
        checkOutput("tmo.busyMid", busy, 1);
        checkOutput("tmo.errMid", err, 0);
        repeat (TIMEOUT / 2 - 40) @(negedge clock);
        checkOutput("tmo.errLate", err, 0);
        repeat (60) @(negedge clock);
        checkOutput("tmo.err", err, 1);
        checkOutput("tmo.busy", busy, 0);
        expErr = 1'b1;

        // Reset in the middle of a frame, after one word has been written.
        txBytes.delete();
        txBytes.push_back(8'hA5);
        txBytes.push_back(8'h00);
        txBytes.push_back(8'h02);
        txBytes.push_back(8'h12);
        txBytes.push_back(8'h34);
        applyStimulus(0);
        checkOutput("mid.busy", busy, 1);
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("mid.data", ir_m_data, 0);
        checkOutput("mid.addr", ir_m_addr, 0);
        checkOutput("mid.wren", ir_m_wren, 0);
        checkOutput("mid.rbusy", busy, 0);
        checkOutput("mid.done", done, 0);
        checkOutput("mid.err", err, 0);
        checkOutput("mid.wl", words_loaded, 0);
        checkOutput("mid.tx", tx, 1);
        rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        expErr = 1'b0;
        expWl  = 0;
        repeat (2 * DIV) @(negedge clock);
        txBytes.delete();
        for (int k = 0; k < 8; k++) begin
            txBytes.push_back(vecs[0].bytes[63-8*k -: 8]);
        end
        runModelFrame("recover", 2);

        // Random frames. The first one is full size, with its last write at
        // the top address.
        for (int f = 0; f < 6; f++) begin
            buildFrame((f == 0) ? WORDS : int'($urandom_range(1, 12)),
                       (f != 0) && ($urandom_range(0, 3) == 0),
                       int'($urandom_range(0, 2)));
            runModelFrame($sformatf("rnd%0d", f), DIV);
        end

`ifdef UART_IR_LOADER_ECHO_EN
        repeat (15 * DIV) @(negedge clock);
        echoQ.delete();
        txBytes.delete();
        txBytes.push_back(8'hA5);
        txBytes.push_back(8'h00);
        txBytes.push_back(8'h01);
        txBytes.push_back(8'hFF);
        txBytes.push_back(8'hFF);
        txBytes.push_back(8'h01);
        runModelFrame("echo", 0);
        repeat (12 * DIV) @(negedge clock);
        checkOutput("echo.count", echoQ.size(), txBytes.size());
        for (int k = 0; k < txBytes.size() && k < echoQ.size(); k++) begin
            checkOutput($sformatf("echo.byte%0d", k), echoQ[k], {1'b1, txBytes[k]});
        end
`endif

        gotA = ir_m_addr;
        gotD = ir_m_data;
        repeat (4) @(negedge clock);
        checkOutput("hold.addr", ir_m_addr, gotA);
        checkOutput("hold.data", ir_m_data, gotD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_ir_loader.md
Name: uart_ir_loader

Overview:
- Upstream feeder for the instruction RAM. Receives a program image over a UART RX pin and writes 16-bit words into ir RAM through the same data/address/wren interface the processor uses.
- Raises busy while loading; top level holds the processor in reset on busy.
- Pulses done on a verified frame, raises err on a bad frame.

Parameters:
- CLK_HZ, 60000000, system clock frequency (PLL output).
- BAUD, 115200, UART bit rate.
- ADDR_W, 12, ir RAM address width; max words = 2^ADDR_W.
- TIMEOUT, 6000000, idle cycles allowed between bytes inside a frame (100 ms).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- rx  in  1  UART receive line, asynchronous, idle high.
- ir_m_data  out  16  write data to ir RAM.
- ir_m_addr  out  ADDR_W  write address to ir RAM.
- ir_m_wren  out  1  one-cycle write strobe.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse, frame accepted.
- err  out  1  sticky error flag.
- words_loaded  out  ADDR_W+1  word count of the last accepted frame.
- tx  out  1  UART transmit line; see Optional Feature.

Behaviour:
- Reset values: all outputs 0, except tx=1. FSM goes to IDLE and the RX sampler goes idle.
- RX sampler:
  - rx passes through a 2-flop synchronizer (reset to 1).
  - DIV = (CLK_HZ + BAUD/2)/BAUD, which is 521 at the defaults.
  - A falling edge starts a count of DIV/2. If the line is high at that point, the start is false: return to idle with no byte.
  - Then 8 data bits, LSB first, each sampled DIV cycles apart.
  - The stop bit is sampled DIV later. Stop=1 gives a one-cycle byte_valid with the byte. Stop=0 is a framing error.
  - The sampler rearms on the first idle-high cycle after the stop sample.
- Frame format, all bytes: 0xA5, N_hi, N_lo, then N words as hi byte then lo byte, then CSUM.
  - CSUM = XOR of every byte after 0xA5 and before CSUM.
- FSM states and transitions:
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 sets busy=1, clears err, clears the running XOR, sets the address counter to 0, and goes to LEN_H.
  - LEN_H: store N[15:8]; go to LEN_L.
  - LEN_L: store N[7:0]. N==0 or N>2^ADDR_W goes to ERR; otherwise go to DATA_H.
  - DATA_H: latch the hi byte; go to DATA_L.
  - DATA_L: on the cycle after the lo byte's byte_valid, drive ir_m_data={hi,lo} and ir_m_addr=counter with ir_m_wren=1 for exactly one cycle. Then increment the counter. If counter==N, go to CSUM; else go to DATA_H.
  - CSUM: byte == running XOR sets words_loaded=N, pulses done one cycle, sets busy=0, and goes to IDLE. A mismatch goes to ERR.
  - ERR: one cycle; err=1, busy=0, go to IDLE.
- Data and address hold rules:
  - ir_m_addr and ir_m_data hold their values outside the write cycle.
  - The RAM is clocked on the inverted clock, so data and address are stable at the write edge.
- Writes are not rolled back on a checksum error; err tells software the image is invalid.
- Timeout:
  - A counter runs in any state except IDLE and resets on each byte_valid.
  - Reaching TIMEOUT goes to ERR.
- A framing error in any non-IDLE state goes to ERR. In IDLE it is ignored.
- Address wrap cannot occur: N is bounded by 2^ADDR_W.
- Reset mid-frame: immediate return to IDLE with outputs at reset values. A partial image stays in RAM.
- A header byte 0xA5 inside a frame is treated as data, not as a restart.

Optional Feature:
- Macro: UART_IR_LOADER_ECHO_EN.
- Defined: an 8N1 transmitter at the same DIV echoes every byte_valid byte on tx.
  - Uses a one-byte holding register.
  - If a new byte arrives while the transmitter is still busy, the holding register is overwritten. This cannot occur at matching baud rates.
- Undefined: tx is tied to 1 and no transmitter logic is built.

Test Plan:
- Sync and load: send A5 00 02 12 34 AB CD, CSUM=00^02^12^34^AB^CD=0x42. Required: writes 0x1234@0 and 0xABCD@1, one wren cycle each; done pulses once; words_loaded=2; busy falls; err=0.
- Bad checksum: same frame with CSUM=0x43 -> both words written, err=1, done never pulses, busy=0.
- Length bounds: N=0x0000 -> err=1 after N_lo. N=0x1001 -> err=1. N=0x1000 with 4096 words -> last write at addr 0xFFF, done pulses.
- Noise and false start: 0x00, 0xFF, then a 100-cycle low glitch, then a valid frame -> only the valid frame is loaded, err=0.
- Timeout and reset: stop after DATA_H; after 6000000 idle cycles err=1 and busy=0. Separately, assert reset mid-frame -> all outputs 0, tx=1, the next valid frame loads correctly.
- Echo (macro defined): send A5 00 01 FF FF 01 -> tx reproduces the same six bytes, with the same 8N1 framing and DIV.
